// File: rtl/esp_resp_parser_pkg.sv
`default_nettype none
// ============================================================================
// Module  : esp_pkg
// Purpose : Shared constants for the ESP AT response parser: line control
//           characters, response-code encodings, keyword byte patterns and
//           the parser state type.
// Rev     : 1.0 - initial release
// ============================================================================
package esp_pkg;

  // Line control characters
  localparam logic [7:0] CHAR_CR = 8'h0D;
  localparam logic [7:0] CHAR_LF = 8'h0A;

  // resp_code encodings
  localparam logic [1:0] RESP_OTHER = 2'd0;
  localparam logic [1:0] RESP_OK    = 2'd1;
  localparam logic [1:0] RESP_ERROR = 2'd2;
  localparam logic [1:0] RESP_READY = 2'd3;

  // Keyword bytes, first character in the most significant byte
  localparam logic [15:0] KW_OK    = 16'h4F4B;         // "OK"
  localparam logic [39:0] KW_ERROR = 40'h4552524F52;   // "ERROR"
  localparam logic [39:0] KW_READY = 40'h7265616479;   // "ready"

  // Parser FSM states
  typedef enum logic [1:0] {
    ST_COLLECT  = 2'd0,
    ST_CLASSIFY = 2'd1,
    ST_HOLD     = 2'd2
  } parse_state_t;

endpackage : esp_pkg
`default_nettype wire

// File: rtl/esp_resp_parser_kw_match.sv
`default_nettype none
// ============================================================================
// Module  : esp_kw_match
// Purpose : Combinational ESP AT keyword classifier. Compares the first five
//           line bytes against "OK", "ERROR" and "ready" with an exact length
//           match; overflowed lines are always OTHER.
// Rev     : 1.0 - initial release
// ============================================================================
module esp_kw_match
  import esp_pkg::*;
#(
  parameter int LEN_W = 7
) (
  input  logic [39:0]      head_i,      // bytes 0..4, byte 0 in [39:32]
  input  logic [LEN_W-1:0] len_i,
  input  logic             ovf_i,
  output logic [1:0]       resp_code_o
);

  // Exact-length, case-sensitive keyword compare
  always_comb begin
    resp_code_o = RESP_OTHER;
    if (!ovf_i) begin
      if ((len_i == LEN_W'(2)) && (head_i[39:24] == KW_OK)) begin
        resp_code_o = RESP_OK;
      end else if ((len_i == LEN_W'(5)) && (head_i == KW_ERROR)) begin
        resp_code_o = RESP_ERROR;
      end else if ((len_i == LEN_W'(5)) && (head_i == KW_READY)) begin
        resp_code_o = RESP_READY;
      end
    end
  end

endmodule : esp_kw_match
`default_nettype wire

// File: rtl/esp_resp_parser.sv
`default_nettype none
// ============================================================================
// Module  : esp_resp_parser
// Purpose : Assembles LF-terminated ESP32 UART response lines into a local
//           buffer, classifies them and hands them to the command sequencer
//           over a valid/ready line handshake. Back-pressures the UART while
//           a completed line is held.
// Options : ESP_RESP_TIMEOUT_EN - discard a partial line after TIMEOUT_CYC
//           idle cycles and pulse line_timeout.
// Rev     : 1.0 - initial release
// ============================================================================
module esp_resp_parser
  import esp_pkg::*;
#(
  parameter int MAX_LEN     = 64,
  parameter int TIMEOUT_CYC = 1_000_000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [7:0]                 rx_data,
  input  logic                       rx_valid,
  output logic                       rx_ready,
  output logic                       line_valid,
  input  logic                       line_ready,
  output logic [$clog2(MAX_LEN):0]   line_len,
  output logic                       line_ovf,
  output logic [1:0]                 resp_code,
  input  logic [$clog2(MAX_LEN)-1:0] rd_addr,
  output logic [7:0]                 rd_data,
  output logic                       line_timeout
);

  localparam int AW    = $clog2(MAX_LEN);
  localparam int LEN_W = AW + 1;

  parse_state_t     state_q;
  logic [LEN_W-1:0] count_q;
  logic             ovf_q;
  logic             rx_ready_q;
  logic             line_valid_q;
  logic [LEN_W-1:0] line_len_q;
  logic             line_ovf_q;
  logic [1:0]       resp_code_q;
  logic [7:0]       line_buf_q [MAX_LEN];

  logic             w_rx_xfer;
  logic             w_is_data;
  logic             w_room;
  logic             w_wr_en;
  logic [1:0]       w_resp_code;
  logic [39:0]      w_head;

  // rx_ready_q is only ever set in COLLECT, so a transfer implies COLLECT
  assign w_rx_xfer = rx_valid & rx_ready_q;
  assign w_is_data = (rx_data != CHAR_CR) && (rx_data != CHAR_LF);
  assign w_room    = (count_q < LEN_W'(MAX_LEN));
  assign w_wr_en   = w_rx_xfer & w_is_data & w_room;
  assign w_head    = {line_buf_q[0], line_buf_q[1], line_buf_q[2],
                      line_buf_q[3], line_buf_q[4]};

  esp_kw_match #(
    .LEN_W (LEN_W)
  ) u_kw_match (
    .head_i      (w_head),
    .len_i       (count_q),
    .ovf_i       (ovf_q),
    .resp_code_o (w_resp_code)
  );

`ifdef ESP_RESP_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  logic [TO_W-1:0] idle_cnt_q;
  logic            line_timeout_q;
  assign line_timeout = line_timeout_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYC != 0);
  assign line_timeout       = 1'b0;
`endif

  // Line buffer storage; contents are only meaningful up to line_len
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      line_buf_q[count_q[AW-1:0]] <= rx_data;
    end
  end

  // Parser FSM with registered handshake and line outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_COLLECT;
      count_q        <= '0;
      ovf_q          <= 1'b0;
      rx_ready_q     <= 1'b0;
      line_valid_q   <= 1'b0;
      line_len_q     <= '0;
      line_ovf_q     <= 1'b0;
      resp_code_q    <= RESP_OTHER;
`ifdef ESP_RESP_TIMEOUT_EN
      idle_cnt_q     <= '0;
      line_timeout_q <= 1'b0;
`endif
    end else begin
`ifdef ESP_RESP_TIMEOUT_EN
      line_timeout_q <= 1'b0;
`endif
      case (state_q)
        ST_COLLECT: begin
          rx_ready_q <= 1'b1;
          if (w_rx_xfer) begin
`ifdef ESP_RESP_TIMEOUT_EN
            idle_cnt_q <= '0;
`endif
            if (rx_data == CHAR_LF) begin
              // Blank lines are swallowed; a non-empty line is closed
              if (count_q != '0) begin
                state_q    <= ST_CLASSIFY;
                rx_ready_q <= 1'b0;
              end
            end else if (rx_data != CHAR_CR) begin
              // Count saturates at MAX_LEN; excess bytes only flag overflow
              if (w_room) begin
                count_q <= count_q + 1'b1;
              end else begin
                ovf_q <= 1'b1;
              end
            end
          end
`ifdef ESP_RESP_TIMEOUT_EN
          else if (count_q != '0) begin
            if (idle_cnt_q == TO_W'(TIMEOUT_CYC - 1)) begin
              idle_cnt_q     <= '0;
              count_q        <= '0;
              ovf_q          <= 1'b0;
              line_timeout_q <= 1'b1;
            end else begin
              idle_cnt_q <= idle_cnt_q + 1'b1;
            end
          end
`endif
        end
        ST_CLASSIFY: begin
          resp_code_q  <= w_resp_code;
          line_len_q   <= count_q;
          line_ovf_q   <= ovf_q;
          line_valid_q <= 1'b1;
          state_q      <= ST_HOLD;
        end
        ST_HOLD: begin
          if (line_ready) begin
            count_q      <= '0;
            ovf_q        <= 1'b0;
            line_valid_q <= 1'b0;
            rx_ready_q   <= 1'b1;
            state_q      <= ST_COLLECT;
          end
        end
        default: begin
          state_q    <= ST_COLLECT;
          rx_ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign rx_ready   = rx_ready_q;
  assign line_valid = line_valid_q;
  assign line_len   = line_len_q;
  assign line_ovf   = line_ovf_q;
  assign resp_code  = resp_code_q;
  assign rd_data    = line_buf_q[rd_addr];

endmodule : esp_resp_parser
`default_nettype wire
